// File: rtl/mio_bus_responder.sv
// Responder for the CPU memory/IO handshake: decodes the request, runs a fixed-length
// access to block RAM, GPIO or the cycle counter, and returns MIO_ready with read data.
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Cpu_data2bus,
  output logic              MIO_ready,
  output logic [31:0]       Cpu_data4bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] T_RAM  = 2'd0;
  localparam logic [1:0] T_GPIO = 2'd1;
  localparam logic [1:0] T_CNT  = 2'd2;
  localparam logic [1:0] T_NONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [RAM_AW-1:0] raddr_q, raddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        tsel_q, tsel_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [15:0]       led_q, led_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [1:0]  tsel_in;
  logic [31:0] rd_mux;
  logic        wr_cycle;
  logic        unused_addr;

  // Only part of the byte address is decoded; upper RAM bits alias by design.
  assign unused_addr = ^addr_bus;

  always_comb begin
    tsel_in = T_RAM;
    if (addr_bus[31:28] == 4'hF) begin
      case (addr_bus[3:2])
        2'd0:    tsel_in = T_GPIO;
        2'd1:    tsel_in = T_CNT;
        default: tsel_in = T_NONE;
      endcase
    end
  end

  always_comb begin
    case (tsel_q)
      T_RAM:   rd_mux = ram_dout;
      T_GPIO:  rd_mux = {16'h0, sw_in};
      T_CNT:   rd_mux = cnt_q;
      default: rd_mux = 32'h0;
    endcase
  end

  // The first WAIT cycle is the only one in which side effects are issued.
  assign wr_cycle = (state_q == S_WAIT) && (wcnt_q == 4'(WAIT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    tsel_d  = tsel_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    led_d   = led_q;
    cnt_d   = cnt_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (CPU_MIO) begin
          raddr_d = addr_bus[RAM_AW+1:2];
          wdata_d = Cpu_data2bus;
          we_d    = mem_w;
          tsel_d  = tsel_in;
          wcnt_d  = 4'(WAIT_CYCLES - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wr_cycle && we_q) begin
          if (tsel_q == T_GPIO) led_d = wdata_q[15:0];
          if (tsel_q == T_CNT)  cnt_d = wdata_q;
        end
        if (wcnt_q == 4'd0) begin
          if (!we_q) rdata_d = rd_mux;
          ready_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // Ready is shown for at least one cycle even if the CPU already let go.
        if (ready_q && !CPU_MIO) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      tsel_q  <= T_RAM;
      rdata_q <= '0;
      ready_q <= 1'b0;
      led_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      tsel_q  <= tsel_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by rst_n so a reset during the write cycle abandons the RAM write.
  assign ram_we       = rst_n && wr_cycle && we_q && (tsel_q == T_RAM);
  assign ram_addr     = raddr_q;
  assign ram_din      = wdata_q;
  assign MIO_ready    = ready_q;
  assign Cpu_data4bus = rdata_q;
  assign led_out      = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder with a behavioural synchronous-read RAM.
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] Cpu_data2bus;
  logic        MIO_ready;
  logic [31:0] Cpu_data4bus;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [15:0] sw_in;
  logic [15:0] led_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  logic [9:0]  we_addr = '0;
  logic        mem_init = 1'b0;
  logic [31:0] mem [0:1023];

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .addr_bus(addr_bus), .Cpu_data2bus(Cpu_data2bus), .MIO_ready(MIO_ready),
    .Cpu_data4bus(Cpu_data4bus), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
    end
    ram_dout <= mem_init ? mem[ram_addr] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full four-phase access; called #1 after a clock edge.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int hold, output logic [31:0] rd, output int e0);
    int k;
    CPU_MIO = 1'b1; mem_w = w; addr_bus = a; Cpu_data2bus = d;
    @(posedge clk); #1;
    e0 = cyc;
    k = 0;
    while (!MIO_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'd3);
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) chk("ready_held", {31'h0, MIO_ready}, 32'd1);
    rd = Cpu_data4bus;
    CPU_MIO = 1'b0; mem_w = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", {31'h0, MIO_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int e0, e0w, e0r, w0;
    rst_n = 1'b0; CPU_MIO = 1'b1; mem_w = 1'b0;
    addr_bus = 32'hF000_0004; Cpu_data2bus = 32'h0; sw_in = 16'h5A5A;

    // reset held with a pending request
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, MIO_ready}, 32'd0);
    chk("rst_we", {31'h0, ram_we}, 32'd0);
    chk("rst_led", {16'h0, led_out}, 32'd0);
    chk("rst_rdata", Cpu_data4bus, 32'd0);
    rst_n = 1'b1;
    // counter is 0 after reset; the capture sees it two increments later
    access(32'hF000_0004, 1'b0, 32'h0, 0, rd, e0);
    chk("rst_cnt_read", rd, 32'd2);

    // RAM write then read back
    w0 = we_cnt;
    access(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, rd, e0);
    chk("ram_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("ram_we_addr", {22'h0, we_addr}, 32'd4);
    chk("wr_keeps_rdata", rd, 32'd2);
    access(32'h0000_0010, 1'b0, 32'h0, 0, rd, e0);
    chk("ram_read", rd, 32'hDEAD_BEEF);
    // upper RAM address bits alias onto the same word
    access(32'h0000_1012, 1'b0, 32'h0, 0, rd, e0);
    chk("ram_alias", rd, 32'hDEAD_BEEF);

    // GPIO
    access(32'hF000_0000, 1'b1, 32'h1234_ABCD, 0, rd, e0);
    chk("led", {16'h0, led_out}, 32'h0000_ABCD);
    access(32'hF000_0000, 1'b0, 32'h0, 0, rd, e0);
    chk("sw_read", rd, 32'h0000_5A5A);

    // counter load and wrap
    access(32'hF000_0004, 1'b1, 32'hFFFF_FFFE, 0, rd, e0w);
    access(32'hF000_0004, 1'b0, 32'h0, 0, rd, e0r);
    chk("cnt_wrap", rd, 32'hFFFF_FFFE + 32'(e0r - e0w));
    chk("cnt_wrap_val", rd, 32'd3);

    // held request after a RAM write: one pulse only
    w0 = we_cnt;
    access(32'h0000_0020, 1'b1, 32'h0000_55AA, 10, rd, e0);
    chk("hold_we_pulses", 32'(we_cnt - w0), 32'd1);
    access(32'h0000_0020, 1'b0, 32'h0, 0, rd, e0);
    chk("hold_read", rd, 32'h0000_55AA);

    // unmapped IO
    access(32'hF000_0008, 1'b0, 32'h0, 0, rd, e0);
    chk("unmapped_read", rd, 32'h0);
    access(32'hF000_000C, 1'b1, 32'hFFFF_FFFF, 0, rd, e0);
    chk("unmapped_wr_led", {16'h0, led_out}, 32'h0000_ABCD);

    // CPU_MIO dropped during WAIT: ready high for exactly one cycle
    sw_in = 16'hC3C3;
    CPU_MIO = 1'b1; mem_w = 1'b0; addr_bus = 32'hF000_0000;
    @(posedge clk); #1;
    CPU_MIO = 1'b0;
    @(posedge clk); #1;
    chk("viol_e1", {31'h0, MIO_ready}, 32'd0);
    @(posedge clk); #1;
    chk("viol_e2", {31'h0, MIO_ready}, 32'd0);
    @(posedge clk); #1;
    chk("viol_e3", {31'h0, MIO_ready}, 32'd1);
    chk("viol_data", Cpu_data4bus, 32'h0000_C3C3);
    @(posedge clk); #1;
    chk("viol_e4", {31'h0, MIO_ready}, 32'd0);

    // reset during the write cycle of a RAM write
    w0 = we_cnt;
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'h0000_0030; Cpu_data2bus = 32'h0000_1111;
    @(posedge clk); #1;
    rst_n = 1'b0; CPU_MIO = 1'b0; mem_w = 1'b0;
    #1;
    chk("midrst_we", {31'h0, ram_we}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_ready", {31'h0, MIO_ready}, 32'd0);
    chk("midrst_pulses", 32'(we_cnt - w0), 32'd0);
    chk("midrst_led", {16'h0, led_out}, 32'd0);
    chk("midrst_rdata", Cpu_data4bus, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(32'h0000_0030, 1'b0, 32'h0, 0, rd, e0);
    chk("midrst_ram", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
